vga_pattern_gen: RTL

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pattern_gen.sv | 132 +++++++++++++
 1 files changed

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: two-stage pixel pipeline that turns timing-stage coordinates
// into one of eight test patterns. Every pipeline register advances only on a
// pix_en strobe. The syncs travel alongside so that they stay aligned with rgb.
module vga_pattern_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [2:0]  sw,
    output logic        h_sync,
    output logic        v_sync,
    output logic [11:0] rgb
);

    localparam logic [2:0] MODE_BLACK   = 3'd0;
    localparam logic [2:0] MODE_WHITE   = 3'd1;
    localparam logic [2:0] MODE_BARS    = 3'd2;
    localparam logic [2:0] MODE_CHECK   = 3'd3;
    localparam logic [2:0] MODE_GREY    = 3'd4;
    localparam logic [2:0] MODE_SQUARE  = 3'd5;
    localparam logic [2:0] MODE_BORDER  = 3'd6;
    localparam logic [2:0] MODE_BLUERMP = 3'd7;

    // switch synchroniser
    logic [2:0]  r_sw_meta, r_sw_sync;
    // stage 1
    logic [9:0]  r_x1, r_y1;
    logic        r_von1, r_hs1, r_vs1;
    logic [2:0]  r_mode;
    logic [7:0]  r_frame_cnt;
    // stage 2
    logic [11:0] r_rgb2;
    logic        r_hs2, r_vs2;

    logic        w_frame_start;
    logic [9:0]  w_sq_lo, w_sq_hi;
    logic [11:0] w_color;

    assign w_frame_start = pix_en && (x == 10'd0) && (y == 10'd0);

    // Two-flop synchroniser for the board switches; runs on every clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_meta <= 3'd0;
            r_sw_sync <= 3'd0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    // Stage 1: capture the pixel, and at frame start latch the mode and bump the frame count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x1        <= 10'd0;
            r_y1        <= 10'd0;
            r_von1      <= 1'b0;
            r_hs1       <= 1'b1;
            r_vs1       <= 1'b1;
            r_mode      <= MODE_BLACK;
            r_frame_cnt <= 8'd0;
        end else if (pix_en) begin
            r_x1   <= x;
            r_y1   <= y;
            r_von1 <= video_on;
            r_hs1  <= h_sync_in;
            r_vs1  <= v_sync_in;
            if (w_frame_start) begin
                r_mode      <= r_sw_sync;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // Colour decode from the stage-1 pixel. Bars use range compares rather than a divide.
    always_comb begin
        w_sq_lo = {1'b0, r_frame_cnt, 1'b0};
        w_sq_hi = w_sq_lo + 10'd31;
        w_color = 12'h000;
        case (r_mode)
            MODE_BLACK:  w_color = 12'h000;
            MODE_WHITE:  w_color = 12'hFFF;
            MODE_BARS: begin
                if      (r_x1 < 10'd80)  w_color = 12'hFFF;
                else if (r_x1 < 10'd160) w_color = 12'hFF0;
                else if (r_x1 < 10'd240) w_color = 12'h0FF;
                else if (r_x1 < 10'd320) w_color = 12'h0F0;
                else if (r_x1 < 10'd400) w_color = 12'hF0F;
                else if (r_x1 < 10'd480) w_color = 12'hF00;
                else if (r_x1 < 10'd560) w_color = 12'h00F;
                else                     w_color = 12'h000;
            end
            MODE_CHECK:  w_color = (r_x1[5] ^ r_y1[5]) ? 12'hFFF : 12'h000;
            MODE_GREY:   w_color = {r_x1[9:6], r_x1[9:6], r_x1[9:6]};
            MODE_SQUARE: begin
                if ((r_x1 >= w_sq_lo) && (r_x1 <= w_sq_hi) &&
                    (r_y1 >= 10'd224) && (r_y1 <= 10'd255))
                    w_color = 12'h0F0;
            end
            MODE_BORDER: begin
                if ((r_x1 < 10'd8) || (r_x1 >= 10'd632) ||
                    (r_y1 < 10'd8) || (r_y1 >= 10'd472))
                    w_color = 12'hF00;
            end
            MODE_BLUERMP: w_color = {8'h00, r_y1[8:5]};
        endcase
        if (!r_von1)
            w_color = 12'h000;
    end

    // Stage 2: register the colour and the second sync delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb2 <= 12'h000;
            r_hs2  <= 1'b1;
            r_vs2  <= 1'b1;
        end else if (pix_en) begin
            r_rgb2 <= w_color;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
        end
    end

    assign rgb    = r_rgb2;
    assign h_sync = r_hs2;
    assign v_sync = r_vs2;

endmodule
